// File: rtl/ysyx_23060124_ifu.sv
// ysyx_23060124_ifu -- instruction fetch unit.
//
// Holds the PC and fetches one 32-bit instruction at a time over an AXI-style
// AR/R read channel. It hands {o_ins, o_pc} to the decode stage and accepts
// redirects from branch/jump/trap resolution. At most one fetch is in flight.
//
// Handshakes: every channel is valid/ready. A transfer happens on the rising
// clock edge where both valid and ready are high. Once valid is raised, the
// producer holds valid and its payload stable until that transfer.
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   o_araddr/o_arvalid/o_arsize, i_arready     read address channel
//   i_rdata/i_rresp/i_rvalid, o_rready         read data channel
//   o_ins/o_pc/o_valid, i_ready                instruction output to decoder
//   i_redirect, i_redirect_pc                  one-cycle redirect pulse + target
//   o_err                 fetch access fault, meaningful while o_valid=1
//   dbg_state             current FSM state (S_IDLE=0, S_AR=1, S_R=2, S_OUT=3)
//
// Configuration macro: IFU_RRESP_CHK_EN. When it is defined, a non-OKAY read
// response raises o_err. When it is undefined, i_rresp is ignored and o_err=0.
`timescale 1ns/1ps
module ysyx_23060124_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  output logic [2:0]  o_arsize,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_ins,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_OUT = 2'd3} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] araddr_q;
  logic        discard, discard_n;
  logic        capture;
  logic [31:0] target;
  logic        unused_bits;

  assign target      = {i_redirect_pc[31:2], 2'b00};
  assign unused_bits = ^i_redirect_pc[1:0];

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_AR;
        if (i_redirect) pc_n = target;
      end
      S_AR: begin
        // The address already on the bus stays put. Its data is dropped later.
        if (i_redirect) begin
          pc_n      = target;
          discard_n = 1'b1;
        end
        if (i_arready) state_n = S_R;
      end
      S_R: begin
        if (i_rvalid) begin
          if (discard || i_redirect) begin
            // Stale beat: drop it and start fetching at the (possibly new) pc.
            state_n   = S_AR;
            discard_n = 1'b0;
            if (i_redirect) pc_n = target;
          end else begin
            capture = 1'b1;
            state_n = S_OUT;
          end
        end else if (i_redirect) begin
          pc_n      = target;
          discard_n = 1'b1;
        end
      end
      S_OUT: begin
        // A redirect takes priority over sequential advance. A same-cycle
        // i_ready still counts as consumed.
        if (i_redirect) begin
          pc_n    = target;
          state_n = S_AR;
        end else if (i_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_AR;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      araddr_q <= RESET_PC;
      o_ins    <= 32'h0000_0013;
      o_pc     <= 32'h0000_0000;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      // The address is latched on entry to S_AR. A later redirect in S_AR
      // then cannot disturb it.
      if (state_n == S_AR && state != S_AR) araddr_q <= pc_n;
      if (capture) begin
        o_ins <= i_rdata;
        o_pc  <= pc;
      end
    end
  end

`ifdef IFU_RRESP_CHK_EN
  logic err_q;
  logic unused_rresp;
  assign unused_rresp = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= (i_rresp != 2'b00);
    end else if (state == S_OUT && (i_ready || i_redirect)) begin
      err_q <= 1'b0;
    end
  end

  assign o_err = err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^i_rresp;
  assign o_err        = 1'b0;
`endif

  assign o_araddr  = araddr_q;
  assign o_arvalid = (state == S_AR);
  assign o_arsize  = 3'b010;
  assign o_rready  = (state == S_R);
  assign o_valid   = (state == S_OUT);
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Bench for ysyx_23060124_ifu.
//
// The driver plays the role of the instruction memory and the decoder, and it
// issues random redirects. The reference model keeps only the address of the
// next instruction that should be delivered. Any other fetch must never reach
// the output.
`timescale 1ns/1ps
module tb_ysyx_23060124_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int W        = 65;
  localparam int N_CYCLES = 3000;
  localparam int IDLE_MAX = 300;

  logic        clock;
  logic        reset;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic [2:0]  o_arsize;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_err;
  logic [1:0]  dbg_state;

  ysyx_23060124_ifu #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .o_arsize(o_arsize), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_ins(o_ins), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_err(o_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory contents and reference model ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction

  function automatic logic bad_fn(input logic [31:0] a);
    return (a[5:2] == 4'hB);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef IFU_RRESP_CHK_EN
    return bad_fn(a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] entry(input logic [31:0] a);
    return {exp_err(a), a, mem_fn(a)};
  endfunction

  // ---------------- driver: memory slave + decoder + redirects ----------------
  logic        ideal;
  logic        done;
  logic        drv_hs_ar, drv_hs_r;
  logic [31:0] drv_addr;
  logic [31:0] pending[$];

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0010;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h3000_0007;
      3:       return 32'h3000_0100;
      4:       return 32'hFFFF_FFF6;
      5:       return 32'h3000_0020;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset = 1'b1; ideal = 1'b1; done = 1'b0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
    i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < N_CYCLES; c++) begin
      @(negedge clock);
      drv_hs_ar = o_arvalid && i_arready;
      drv_addr  = o_araddr;
      drv_hs_r  = i_rvalid && o_rready;
      @(posedge clock);
      #1;
      if (drv_hs_r && pending.size() > 0) void'(pending.pop_front());
      if (drv_hs_ar) pending.push_back(drv_addr);
      if (c == 45) ideal = 1'b0;
      i_arready = ideal ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (pending.size() > 0 && (ideal || $urandom_range(0, 1) == 1)) begin
        i_rvalid = 1'b1;
        i_rdata  = mem_fn(pending[0]);
        i_rresp  = bad_fn(pending[0]) ? 2'b10 : 2'b00;
      end else begin
        i_rvalid = 1'b0;
        i_rdata  = $urandom();
        i_rresp  = 2'($urandom_range(0, 3));
      end
      i_ready       = ideal ? 1'b1 : ($urandom_range(0, 3) != 0);
      i_redirect    = !ideal && ($urandom_range(0, 11) == 0);
      i_redirect_pc = pick_target();
    end
    i_redirect = 1'b0;
    @(posedge clock);
    #1 done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_pc;
  int           n_vec, n_fail, n_acc, cyc, last_valid_cyc, idle_cyc;
  logic         prev_ar_wait;
  logic [31:0]  prev_araddr;
  logic         acc;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, expv);
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0; n_acc = 0; cyc = 0; last_valid_cyc = -1; idle_cyc = 0;
    prev_ar_wait = 1'b0; prev_araddr = 32'h0; model_pc = RESET_PC;
  end

  always @(negedge clock) begin
    if (done) begin
      check("accept_count_min", W'(n_acc >= 20), W'(1));
      check("one_fetch_in_flight", W'(pending.size() <= 1), W'(1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end else if (reset) begin
      check("rst_arvalid", W'(o_arvalid), W'(0));
      check("rst_rready", W'(o_rready), W'(0));
      check("rst_valid", W'(o_valid), W'(0));
      check("rst_ins", W'(o_ins), W'(32'h0000_0013));
      check("rst_err", W'(o_err), W'(0));
      model_pc = RESET_PC;
      exp_q.delete();
      exp_q.push_back(entry(model_pc));
      prev_ar_wait = 1'b0;
      idle_cyc = 0;
    end else begin
      cyc++;
      idle_cyc++;
      if (prev_ar_wait) begin
        check("ar_hold_valid", W'(o_arvalid), W'(1));
        check("ar_hold_addr", W'(o_araddr), W'(prev_araddr));
      end
      if (o_arvalid) check("arsize", W'(o_arsize), W'(3'b010));
      if (o_valid) begin
        if (exp_q.size() == 0) check("valid_without_expect", W'(o_valid), W'(0));
        else check("ins_pc_err", {o_err, o_pc, o_ins}, exp_q[0]);
        if (ideal && last_valid_cyc >= 0) check("throughput_gap", W'(cyc - last_valid_cyc), W'(3));
        last_valid_cyc = cyc;
      end
      acc = o_valid && i_ready;
      if (acc) n_acc++;
      if (i_redirect) begin
        model_pc = {i_redirect_pc[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back(entry(model_pc));
        idle_cyc = 0;
      end else if (acc) begin
        model_pc = model_pc + 32'd4;
        void'(exp_q.pop_front());
        exp_q.push_back(entry(model_pc));
        idle_cyc = 0;
      end
      if (idle_cyc == IDLE_MAX) begin
        n_vec++;
        n_fail++;
        $display("FAIL fetch_timeout @cyc %0d: got no delivery, required one within %0d cycles", cyc, IDLE_MAX);
      end
      prev_ar_wait = o_arvalid && !i_arready;
      prev_araddr  = o_araddr;
    end
  end

endmodule
